// File: rtl/fir_ctrl_pkg.sv
// fir_ctrl_pkg
//   Shared definitions for the FIR run controller. It holds the host opcodes,
//   the FSM state encoding, the err_code values, the length of the core soft
//   reset, and the timer width.
//   Ports: none (package).
//   Optional feature macro used by the controller: FIR_CTRL_PERF_EN.
package fir_ctrl_pkg;

  // Host command opcodes
  localparam logic [1:0] OP_LOAD_COEF = 2'd0;
  localparam logic [1:0] OP_LOAD_DATA = 2'd1;
  localparam logic [1:0] OP_RUN       = 2'd2;
  localparam logic [1:0] OP_ABORT     = 2'd3;

  // err_code values
  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_BADADDR = 2'd1;
  localparam logic [1:0] ERR_NOCOEF  = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  // Number of cycles fir_rstn is held low by an abort or timeout
  localparam int SRST_LEN = 2;

  // Width of the run / soft-reset timer
  localparam int TIMER_W = 24;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_RUN   = 2'd2,
    ST_SRST  = 2'd3
  } state_t;

endpackage

// File: rtl/fir_ctrl_timer.sv
// fir_ctrl_timer
//   Clearable up-counter with a terminal-count compare. The controller uses it
//   as the run watchdog and as the soft-reset length counter. Its count also
//   supplies the run-length measurement.
//   Ports:
//     clk    in   1  clock, rising edge
//     rstn   in   1  asynchronous active-low reset
//     clr    in   1  synchronous clear (has priority over en)
//     en     in   1  count enable
//     limit  in   W  terminal-count value
//     count  out  W  current count
//     tc     out  1  high while count == limit
module fir_ctrl_timer #(
  parameter int W = 24
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic [W-1:0] count,
  output logic         tc
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  // Counter register: clear wins over increment
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + ONE;
    end else begin
      count <= count;
    end
  end

  assign tc = (count == limit);

endmodule

// File: rtl/fir_run_ctrl.sv
// fir_run_ctrl
//   Host-facing sequencer for the FIR core. It accepts one command at a time on
//   a valid/ready port. Each LOAD command becomes a one-cycle coefficient or
//   sample write strobe. A RUN command drives the core start level and then
//   waits for fir_done, guarded by a watchdog. Errors are reported on err_code.
//   Optional feature: define FIR_CTRL_PERF_EN to build the run_cycles
//   measurement register. When the macro is undefined, run_cycles is 0.
//   Ports:
//     clk, rstn                       clock, async active-low reset
//     cmd_valid/cmd_ready             host handshake
//     cmd_op/cmd_addr/cmd_data        host command fields
//     fir_din/fir_addr                core write data/address
//     fir_cload/fir_dload             one-cycle coefficient/sample strobes
//     fir_s                           core start level
//     fir_rstn                        core soft reset, active-low
//     fir_done                        core completion level
//     busy, done_pulse, err_code      status
//     run_cycles                      length of last successful run
module fir_run_ctrl
  import fir_ctrl_pkg::*;
#(
  parameter int ADDR_W     = 14,
  parameter int DATA_W     = 16,
  parameter int NTAPS      = 64,
  parameter int TMO_CYCLES = 2**22
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_data,
  output logic [DATA_W-1:0] fir_din,
  output logic [ADDR_W-1:0] fir_addr,
  output logic              fir_cload,
  output logic              fir_dload,
  output logic              fir_s,
  output logic              fir_rstn,
  input  logic              fir_done,
  output logic              busy,
  output logic              done_pulse,
  output logic [1:0]        err_code,
  output logic [23:0]       run_cycles
);

  localparam int                 CNT_W    = $clog2(NTAPS + 1);
  localparam logic [CNT_W-1:0]   NTAPS_C  = CNT_W'(NTAPS);
  localparam logic [CNT_W-1:0]   CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]    NTAPS_A  = (ADDR_W+1)'(NTAPS);
  localparam logic [TIMER_W-1:0] TMO_LIM  = TIMER_W'(TMO_CYCLES - 1);
  localparam logic [TIMER_W-1:0] SRST_LIM = TIMER_W'(SRST_LEN - 1);

  state_t              state, state_n;
  logic                live;        // low only until the first clock after reset
  logic [CNT_W-1:0]    coef_cnt;
  logic                coef_full;
  logic                addr_ok;

  logic                ready_s;
  logic                cload_n, dload_n, done_n;
  logic [1:0]          err_n;
  logic                coef_inc, coef_clr;
  logic                timer_clr, timer_en;
  logic [TIMER_W-1:0]  timer_count;
  logic                timer_tc;

  logic [DATA_W-1:0]   din_r;
  logic [ADDR_W-1:0]   addr_r;
  logic                cload_r, dload_r, s_r, frstn_r, busy_r, done_r;
  logic [1:0]          err_r;

  assign coef_full = (coef_cnt == NTAPS_C);
  assign addr_ok   = ({1'b0, cmd_addr} < NTAPS_A);

  fir_ctrl_timer #(.W(TIMER_W)) u_timer (
    .clk   (clk),
    .rstn  (rstn),
    .clr   (timer_clr),
    .en    (timer_en),
    .limit (TMO_LIM),
    .count (timer_count),
    .tc    (timer_tc)
  );

  // Next-state, handshake and strobe decode
  always_comb begin
    state_n   = state;
    ready_s   = 1'b0;
    cload_n   = 1'b0;
    dload_n   = 1'b0;
    done_n    = 1'b0;
    err_n     = err_r;
    coef_inc  = 1'b0;
    coef_clr  = 1'b0;
    timer_clr = 1'b0;
    timer_en  = 1'b0;
    case (state)
      ST_IDLE: begin
        ready_s = live;
        if (cmd_valid && live) begin
          err_n = ERR_NONE;
          case (cmd_op)
            OP_LOAD_COEF: begin
              if (addr_ok) begin
                state_n  = ST_WRITE;
                cload_n  = 1'b1;
                coef_inc = 1'b1;
              end else begin
                err_n = ERR_BADADDR;
              end
            end
            OP_LOAD_DATA: begin
              state_n = ST_WRITE;
              dload_n = 1'b1;
            end
            OP_RUN: begin
              if (coef_full) begin
                state_n   = ST_RUN;
                timer_clr = 1'b1;
              end else begin
                err_n = ERR_NOCOEF;
              end
            end
            OP_ABORT: begin
              state_n   = ST_SRST;
              timer_clr = 1'b1;
            end
            default: begin
              state_n = ST_IDLE;
            end
          endcase
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_WRITE: begin
        state_n = ST_IDLE;
      end
      ST_RUN: begin
        // Only ABORT is taken while running; other commands stay pending.
        ready_s  = cmd_valid && (cmd_op == OP_ABORT);
        timer_en = 1'b1;
        // Completion beats timeout, and timeout beats abort. An abort that
        // arrives together with completion is consumed and has no effect.
        if (fir_done) begin
          done_n  = 1'b1;
          state_n = ST_IDLE;
        end else if (timer_tc) begin
          err_n     = ERR_TIMEOUT;
          state_n   = ST_SRST;
          timer_clr = 1'b1;
        end else if (ready_s) begin
          err_n     = ERR_NONE;
          state_n   = ST_SRST;
          timer_clr = 1'b1;
        end else begin
          state_n = ST_RUN;
        end
      end
      ST_SRST: begin
        timer_en = 1'b1;
        coef_clr = 1'b1;
        if (timer_count == SRST_LIM) begin
          state_n = ST_IDLE;
        end else begin
          state_n = ST_SRST;
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= ST_IDLE;
      live    <= 1'b0;
      cload_r <= 1'b0;
      dload_r <= 1'b0;
      s_r     <= 1'b0;
      frstn_r <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      err_r   <= ERR_NONE;
      din_r   <= '0;
      addr_r  <= '0;
    end else begin
      state   <= state_n;
      live    <= 1'b1;
      cload_r <= cload_n;
      dload_r <= dload_n;
      s_r     <= (state_n == ST_RUN);
      frstn_r <= (state_n != ST_SRST);
      busy_r  <= (state_n != ST_IDLE);
      done_r  <= done_n;
      err_r   <= err_n;
      if (cload_n || dload_n) begin
        din_r  <= cmd_data;
        addr_r <= cmd_addr;
      end else begin
        din_r  <= din_r;
        addr_r <= addr_r;
      end
    end
  end

  // Accepted-coefficient counter, saturating at NTAPS
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      coef_cnt <= '0;
    end else if (coef_clr) begin
      coef_cnt <= '0;
    end else if (coef_inc && !coef_full) begin
      coef_cnt <= coef_cnt + CNT_ONE;
    end else begin
      coef_cnt <= coef_cnt;
    end
  end

`ifdef FIR_CTRL_PERF_EN
  logic [23:0] run_cycles_r;

  // Length of the last successful run. The timer reads N-1 on the cycle
  // fir_done is seen, which is the N-th cycle of fir_s.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      run_cycles_r <= 24'd0;
    end else if (done_n) begin
      run_cycles_r <= timer_count + 24'd1;
    end else begin
      run_cycles_r <= run_cycles_r;
    end
  end

  assign run_cycles = run_cycles_r;
`else
  assign run_cycles = 24'd0;
`endif

  assign cmd_ready  = ready_s;
  assign fir_din    = din_r;
  assign fir_addr   = addr_r;
  assign fir_cload  = cload_r;
  assign fir_dload  = dload_r;
  assign fir_s      = s_r;
  assign fir_rstn   = frstn_r;
  assign busy       = busy_r;
  assign done_pulse = done_r;
  assign err_code   = err_r;

endmodule

// File: tb/tb_fir_run_ctrl.sv
// tb_fir_run_ctrl
//   Directed, self-checking bench for fir_run_ctrl. Single-command behaviour
//   comes from a vector table. Runs, timeouts and aborts use hand-written
//   sequences. The watchdog is shortened to TMO cycles so that a 100-cycle run
//   completes and a timeout is still reachable quickly.
module tb_fir_run_ctrl;
  import fir_ctrl_pkg::*;

  localparam int ADDR_W = 14;
  localparam int DATA_W = 16;
  localparam int NTAPS  = 64;
  localparam int TMO    = 128;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [1:0]        cmd_op = 2'd0;
  logic [ADDR_W-1:0] cmd_addr = '0;
  logic [DATA_W-1:0] cmd_data = '0;
  logic [DATA_W-1:0] fir_din;
  logic [ADDR_W-1:0] fir_addr;
  logic              fir_cload, fir_dload, fir_s, fir_rstn;
  logic              fir_done = 1'b0;
  logic              busy, done_pulse;
  logic [1:0]        err_code;
  logic [23:0]       run_cycles;

  int n_checks = 0;
  int n_fail   = 0;

  fir_run_ctrl #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NTAPS(NTAPS), .TMO_CYCLES(TMO)
  ) dut (
    .clk(clk), .rstn(rstn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .fir_din(fir_din), .fir_addr(fir_addr),
    .fir_cload(fir_cload), .fir_dload(fir_dload),
    .fir_s(fir_s), .fir_rstn(fir_rstn), .fir_done(fir_done),
    .busy(busy), .done_pulse(done_pulse), .err_code(err_code),
    .run_cycles(run_cycles)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]        op;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              cload;
    logic              dload;
    logic [1:0]        err;
  } vec_t;

  vec_t vt[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Present a command at a falling edge and hold it until accepted. On return
  // the accepting rising edge (end of cycle T) has just passed.
  task automatic issue(input logic [1:0] op, input logic [ADDR_W-1:0] a,
                       input logic [DATA_W-1:0] d);
    bit got = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_data = d;
    for (int n = 0; n < 300; n++) begin
      #1;
      if (cmd_ready) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (got) begin
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
    end else begin
      cmd_valid = 1'b0;
      n_checks++;
      n_fail++;
      $display("FAIL issue_wait: cmd_ready never rose for op %0d", op);
    end
  endtask

  task automatic fill_coefs(input int first, input int count);
    for (int i = first; i < first + count; i++) begin
      issue(OP_LOAD_COEF, ADDR_W'(i), DATA_W'(i * 7 + 1));
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    int s_hi, first_err, rl;
    bit idle_ok;

    vt[0] = '{OP_LOAD_DATA, 14'h1234, 16'hBEEF, 1'b0, 1'b1, ERR_NONE};
    vt[1] = '{OP_LOAD_COEF, 14'd64,   16'h1111, 1'b0, 1'b0, ERR_BADADDR};
    vt[2] = '{OP_LOAD_DATA, 14'h0001, 16'h5555, 1'b0, 1'b1, ERR_NONE};
    vt[3] = '{OP_LOAD_COEF, 14'd5,    16'hA5A5, 1'b1, 1'b0, ERR_NONE};
    vt[4] = '{OP_LOAD_COEF, 14'h3FFF, 16'h2222, 1'b0, 1'b0, ERR_BADADDR};
    vt[5] = '{OP_LOAD_COEF, 14'd63,   16'h7FFF, 1'b1, 1'b0, ERR_NONE};

    // ---- reset ----
    @(negedge clk); @(negedge clk);
    chk("rst_fir_rstn", fir_rstn, 32'd0);
    chk("rst_cmd_ready", cmd_ready, 32'd0);
    chk("rst_busy", busy, 32'd0);
    chk("rst_err", err_code, 32'd0);
    chk("rst_strobes", {fir_cload, fir_dload, fir_s, done_pulse}, 32'd0);
    rstn = 1'b1;
    @(negedge clk);
    chk("rel_cmd_ready", cmd_ready, 32'd1);
    chk("rel_fir_rstn", fir_rstn, 32'd1);
    chk("rel_busy", busy, 32'd0);
    chk("rel_err", err_code, 32'd0);

    // ---- table of single commands (two valid coef writes) ----
    for (int i = 0; i < 6; i++) begin
      issue(vt[i].op, vt[i].addr, vt[i].data);
      @(negedge clk);
      chk($sformatf("v%0d_cload", i), fir_cload, 32'(vt[i].cload));
      chk($sformatf("v%0d_dload", i), fir_dload, 32'(vt[i].dload));
      chk($sformatf("v%0d_err", i), err_code, 32'(vt[i].err));
      chk($sformatf("v%0d_ready", i), cmd_ready, 32'(!(vt[i].cload || vt[i].dload)));
      if (vt[i].cload || vt[i].dload) begin
        chk($sformatf("v%0d_addr", i), fir_addr, 32'(vt[i].addr));
        chk($sformatf("v%0d_din", i), fir_din, 32'(vt[i].data));
      end
      @(negedge clk);
      chk($sformatf("v%0d_strobe_off", i), {fir_cload, fir_dload}, 32'd0);
      chk($sformatf("v%0d_ready2", i), cmd_ready, 32'd1);
    end

    // ---- 63 coefficients: RUN must be refused ----
    fill_coefs(0, 61);
    issue(OP_RUN, '0, '0);
    @(negedge clk);
    chk("nocoef_err", err_code, 32'(ERR_NOCOEF));
    chk("nocoef_fir_s", fir_s, 32'd0);
    chk("nocoef_busy", busy, 32'd0);

    // ---- 64th coefficient, then a 100-cycle run ----
    fill_coefs(61, 1);
    issue(OP_RUN, '0, '0);
    s_hi = 0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (k == 1) begin
        chk("run_fir_s_t1", fir_s, 32'd1);
        chk("run_err", err_code, 32'd0);
      end
      if (fir_s) s_hi++;
      if (k == 100) fir_done = 1'b1;
    end
    chk("run_s_cycles", s_hi, 32'd100);
    @(negedge clk);
    fir_done = 1'b0;
    chk("run_done_pulse", done_pulse, 32'd1);
    chk("run_fir_s_off", fir_s, 32'd0);
    chk("run_busy_off", busy, 32'd0);
`ifdef FIR_CTRL_PERF_EN
    chk("run_cycles", run_cycles, 32'd100);
`else
    chk("run_cycles_zero", run_cycles, 32'd0);
`endif
    @(negedge clk);
    chk("run_done_once", done_pulse, 32'd0);
    issue(OP_LOAD_DATA, 14'h0042, 16'h0042);
    @(negedge clk);
`ifdef FIR_CTRL_PERF_EN
    chk("run_cycles_hold", run_cycles, 32'd100);
`else
    chk("run_cycles_hold0", run_cycles, 32'd0);
`endif

    // ---- watchdog timeout ----
    issue(OP_RUN, '0, '0);
    s_hi = 0; first_err = 0; rl = 0; idle_ok = 1'b0;
    for (int k = 1; k <= TMO + 10; k++) begin
      @(negedge clk);
      if (fir_s) s_hi++;
      if (err_code == ERR_TIMEOUT && first_err == 0) first_err = k;
      if (!fir_rstn) rl++;
      if (k == TMO + 3) idle_ok = cmd_ready && !busy;
    end
    chk("tmo_s_cycles", s_hi, 32'(TMO));
    chk("tmo_err_cycle", first_err, 32'(TMO + 1));
    chk("tmo_rstn_low", rl, 32'd2);
    chk("tmo_idle", idle_ok, 32'd1);
    issue(OP_RUN, '0, '0);
    @(negedge clk);
    chk("tmo_then_nocoef", err_code, 32'(ERR_NOCOEF));

    // ---- ABORT together with fir_done: completion wins ----
    fill_coefs(0, NTAPS);
    issue(OP_RUN, '0, '0);
    @(negedge clk); @(negedge clk); @(negedge clk);
    fir_done = 1'b1; cmd_valid = 1'b1; cmd_op = OP_ABORT;
    #1;
    chk("ab_done_ready", cmd_ready, 32'd1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0; fir_done = 1'b0;
    @(negedge clk);
    chk("ab_done_pulse", done_pulse, 32'd1);
    chk("ab_done_rstn", fir_rstn, 32'd1);
    chk("ab_done_busy", busy, 32'd0);
    @(negedge clk);
    chk("ab_done_no_srst", fir_rstn, 32'd1);

    // ---- ABORT alone; a pending LOAD is not taken while running ----
    issue(OP_RUN, '0, '0);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = OP_LOAD_DATA;
    #1;
    chk("run_hold_load", cmd_ready, 32'd0);
    cmd_op = OP_ABORT;
    #1;
    chk("run_abort_ready", cmd_ready, 32'd1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("abort_rstn1", fir_rstn, 32'd0);
    chk("abort_fir_s", fir_s, 32'd0);
    chk("abort_err", err_code, 32'd0);
    chk("abort_busy", busy, 32'd1);
    @(negedge clk);
    chk("abort_rstn2", fir_rstn, 32'd0);
    @(negedge clk);
    chk("abort_rstn3", fir_rstn, 32'd1);
    chk("abort_ready", cmd_ready, 32'd1);
    issue(OP_RUN, '0, '0);
    @(negedge clk);
    chk("abort_nocoef", err_code, 32'(ERR_NOCOEF));

    // ---- ABORT in IDLE ----
    issue(OP_ABORT, '0, '0);
    @(negedge clk);
    chk("idle_abort_rstn1", fir_rstn, 32'd0);
    chk("idle_abort_err", err_code, 32'd0);
    @(negedge clk);
    chk("idle_abort_rstn2", fir_rstn, 32'd0);
    @(negedge clk);
    chk("idle_abort_rstn3", fir_rstn, 32'd1);

    // ---- rstn asserted mid-run ----
    fill_coefs(0, NTAPS);
    issue(OP_RUN, '0, '0);
    @(negedge clk);
    chk("mid_fir_s", fir_s, 32'd1);
    #2 rstn = 1'b0;
    #1;
    chk("mid_rst_fir_s", fir_s, 32'd0);
    chk("mid_rst_fir_rstn", fir_rstn, 32'd0);
    chk("mid_rst_busy", busy, 32'd0);
    chk("mid_rst_ready", cmd_ready, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    chk("mid_rel_rstn", fir_rstn, 32'd1);
    issue(OP_RUN, '0, '0);
    @(negedge clk);
    chk("mid_rel_nocoef", err_code, 32'(ERR_NOCOEF));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
